// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end with predecode, BTFN prediction and a decoupling FIFO
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h40000060,
    parameter bit          BTFN     = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [31:0]               instr_mem_address,
    output logic                      instr_read,
    input  logic                      instr_mem_resp,
    input  logic [31:0]               instr_mem_rdata,
    input  logic                      redirect,
    input  logic [31:0]               redirect_pc,
    output logic                      deq_valid,
    input  logic                      deq_ready,
    output logic [31:0]               deq_instr,
    output logic [31:0]               deq_pc,
    output logic                      deq_pred_taken,
    output logic [31:0]               deq_pred_target,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_FULL,
        S_DRAIN,
        S_HALT_JALR
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     hold_q, hold_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    entry_t          entries_q [DEPTH];
    entry_t          entries_d [DEPTH];

    logic [6:0]      opcode;
    logic [31:0]     j_imm;
    logic [31:0]     b_imm;
    logic            pred_taken;
    logic [31:0]     pred_target;
    logic            push;
    logic            pop;
    entry_t          head;

    always_comb begin
        opcode      = instr_mem_rdata[6:0];
        j_imm       = {{12{instr_mem_rdata[31]}}, instr_mem_rdata[19:12], instr_mem_rdata[20],
                       instr_mem_rdata[30:21], 1'b0};
        b_imm       = {{20{instr_mem_rdata[31]}}, instr_mem_rdata[7], instr_mem_rdata[30:25],
                       instr_mem_rdata[11:8], 1'b0};
        pred_taken  = 1'b0;
        pred_target = pc_q + 32'd4;
        if (opcode == OP_JAL) begin
            pred_taken  = 1'b1;
            pred_target = pc_q + j_imm;
        end else if (opcode == OP_BR && BTFN && b_imm[31]) begin
            pred_taken  = 1'b1;
            pred_target = pc_q + b_imm;
        end
    end

    // In DRAIN the abandoned request must stay on the bus until the cache answers it.
    always_comb begin
        instr_read        = (state_q == S_FETCH) || (state_q == S_DRAIN);
        instr_mem_address = (state_q == S_DRAIN) ? hold_q : pc_q;
        head              = entries_q[rd_ptr_q];
        deq_valid         = (count_q != '0) && !redirect;
        deq_instr         = head.instr;
        deq_pc            = head.pc;
        deq_pred_taken    = head.taken;
        deq_pred_target   = head.target;
        count             = count_q;
        pop               = deq_valid && deq_ready;
        push              = (state_q == S_FETCH) && instr_mem_resp && !redirect;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hold_d    = hold_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        entries_d = entries_q;

        if (redirect) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pc_d     = redirect_pc;
            if (state_q != S_DRAIN) begin
                hold_d = pc_q;
            end
            state_d = (instr_read && !instr_mem_resp) ? S_DRAIN : S_FETCH;
        end else begin
            if (push) begin
                entries_d[wr_ptr_q] = '{pc: pc_q, instr: instr_mem_rdata,
                                        taken: pred_taken, target: pred_target};
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);

            case (state_q)
                S_RESET: state_d = S_FETCH;
                S_FETCH: begin
                    if (instr_mem_resp) begin
                        pc_d = pred_target;
                        if (opcode == OP_JALR) begin
                            state_d = S_HALT_JALR;
                        end else if (count_d == FULL_COUNT) begin
                            state_d = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (count_q < FULL_COUNT) begin
                        state_d = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (instr_mem_resp) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RESET;
            pc_q     <= RESET_PC;
            hold_q   <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            hold_q   <= hold_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        entries_q <= entries_d;
    end
endmodule
